// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//
// Fetch stage in front of a single-cycle, combinational-read instruction
// memory. The stage holds the program counter and drives it out as the word
// address. The returned instruction is captured into a fetch/decode pipeline
// register. That register is offered to decode through a valid/ready
// handshake. Execute can redirect the PC at any time.
//
// Parameters
//   PC_W      PC / word-address width (16K-word memory -> 14)
//   IW        instruction width
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk           clock, all state on rising edge
//   rst           synchronous active-high reset
//   fetch_en      1 = fetching permitted, 0 = pause
//   imem_addr     word address to instruction memory (the PC register)
//   imem_data     instruction word for imem_addr, same cycle
//   redir_valid   redirect request from execute
//   redir_target  absolute word address to fetch next
//   if_valid      if_ir / if_pc hold a live instruction
//   if_ir         captured instruction
//   if_pc         address of if_ir
//   id_ready      decode accepts if_ir this cycle
//   fetch_state   debug view of FSM: 0 IDLE, 1 RUN, 2 PAUSE
//
// Optional feature (macro FETCH_PERF_CNT_EN)
//   perf_fetched  count of instruction loads into the pipeline register
//   perf_bubbles  count of RUN cycles that leave the pipeline register empty
//   Both counters clear on rst and wrap at 2^32.
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
    parameter int unsigned PC_W     = 14,
    parameter int unsigned IW       = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IW-1:0]   imem_data,
    input  logic            redir_valid,
    input  logic [PC_W-1:0] redir_target,
    output logic            if_valid,
    output logic [IW-1:0]   if_ir,
    output logic [PC_W-1:0] if_pc,
    input  logic            id_ready,
    output logic [1:0]      fetch_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_bubbles
`endif
);

    localparam logic [PC_W-1:0] RESET_PC_V = RESET_PC[PC_W-1:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic            if_valid_reg, if_valid_next;
    logic [IW-1:0]   if_ir_reg, if_ir_next;
    logic [PC_W-1:0] if_pc_reg, if_pc_next;
    logic            ld;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC_V;
            if_valid_reg <= 1'b0;
            if_ir_reg    <= '0;
            if_pc_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            if_valid_reg <= if_valid_next;
            if_ir_reg    <= if_ir_next;
            if_pc_reg    <= if_pc_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        if_valid_next = if_valid_reg;
        if_ir_next    = if_ir_reg;
        if_pc_next    = if_pc_reg;

        // A redirect suppresses the load. The word at the old PC is on the
        // wrong path.
        ld = (state_reg == RUN) && fetch_en && (!if_valid_reg || id_ready)
             && !redir_valid;

        case (state_reg)
            IDLE:    state_next = RUN;
            RUN:     if (!fetch_en) state_next = PAUSE;
            // A redirect while paused only moves the PC; fetching resumes
            // on a later cycle with fetch_en high.
            PAUSE:   if (fetch_en && !redir_valid) state_next = RUN;
            default: state_next = IDLE;
        endcase

        if (redir_valid) begin
            // The flush applies even while decode is stalled.
            pc_next       = redir_target;
            if_valid_next = 1'b0;
        end else if (ld) begin
            if_ir_next    = imem_data;
            if_pc_next    = pc_reg;
            if_valid_next = 1'b1;
            pc_next       = pc_reg + PC_W'(1);   // wraps modulo 2^PC_W
        end else if (if_valid_reg && id_ready) begin
            if_valid_next = 1'b0;
        end
    end

    assign imem_addr   = pc_reg;
    assign if_valid    = if_valid_reg;
    assign if_ir       = if_ir_reg;
    assign if_pc       = if_pc_reg;
    assign fetch_state = state_reg;

`ifdef FETCH_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Performance counters
    //   index 0: loads
    //   index 1: RUN cycles ending with an empty pipeline register
    // -------------------------------------------------------------------------
    logic [1:0] perf_inc;

    assign perf_inc[0] = ld;
    assign perf_inc[1] = (state_reg == RUN) && !if_valid_next;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            logic [31:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (perf_inc[gi]) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign perf_fetched = g_perf[0].cnt_reg;
    assign perf_bubbles = g_perf[1].cnt_reg;
`endif

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Fetch stage sitting directly upstream of the 16K-word instruction memory. It owns the program counter, drives the memory's word address, and captures the returned 32-bit instruction into a fetch/decode pipeline register. It presents the instruction to decode with a valid/ready handshake and accepts PC redirects (jumps, branches) from execute.

## Interface
- `PC_W`, 14, PC and word-address width; matches the 16384-word instruction memory.
- `IW`, 32, instruction width.
- `RESET_PC`, 0, PC value loaded on reset.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_en`  in  1  1 = fetch permitted; 0 = pause fetching.
- `imem_addr`  out  PC_W  word address to instruction memory (= PC register).
- `imem_data`  in  IW  instruction word from memory, combinational from `imem_addr`.
- `redir_valid`  in  1  redirect request from execute.
- `redir_target`  in  PC_W  absolute word address to fetch next.
- `if_valid`  out  1  `if_ir` / `if_pc` hold a live instruction.
- `if_ir`  out  IW  captured instruction.
- `if_pc`  out  PC_W  address of `if_ir`.
- `id_ready`  in  1  decode accepts `if_ir` this cycle.
- `fetch_state`  out  2  FSM state, for debug: 0 IDLE, 1 RUN, 2 PAUSE.

## Operation
- Single-cycle memory: `imem_data` for the current PC is valid in the same cycle; no request handshake.
- Transfer out: an instruction is consumed on any edge with `if_valid && id_ready`.
- Load condition `ld = (state==RUN) && fetch_en && (!if_valid || id_ready)`. On `ld`: `if_ir<=imem_data`, `if_pc<=PC`, `if_valid<=1`, `PC<=PC+1`.
- Consumed with no load: `if_valid<=0`.
- Stalled (`if_valid && !id_ready`): PC, `if_ir`, `if_pc` and `if_valid` hold unchanged.
- Redirect (`redir_valid`, any state except during reset): `PC<=redir_target`, `if_valid<=0` (flushes the wrong-path word, even if decode is stalled), no load that cycle. Redirect beats load, stall and `fetch_en=0`.
- PC arithmetic: modulo 2^PC_W; `PC=16383` increments to 0. No sign handling here; execute supplies absolute targets.
- FSM:
  - IDLE: entered on reset; exits to RUN on the next edge with `!rst`.
  - RUN: fetches per `ld`; goes to PAUSE when `fetch_en=0`.
  - PAUSE: no loads, PC held; an already-valid `if_ir` remains and may still be consumed; returns to RUN when `fetch_en=1`.
  - A redirect in PAUSE updates PC and flushes, and the FSM stays in PAUSE.

## Timing
- Reset values: `PC=RESET_PC`, `imem_addr=RESET_PC`, `if_valid=0`, `if_ir=0`, `if_pc=0`, `fetch_state=IDLE`.
- `rst` dominates every other input, including a redirect in the same cycle.
- First fetch: `if_valid=1` with `if_pc=RESET_PC` two edges after `rst` falls (one IDLE cycle, one load).
- Throughput with `id_ready` held at 1: one instruction per cycle, with `if_pc` incrementing by 1.
- Redirect penalty: exactly one bubble. On edge N `redir_valid` is sampled. On edge N+1 `if_pc=redir_target` with `if_valid=1`.
- `fetch_en` deasserted: state is PAUSE after the next edge. Re-asserted: RUN after one edge, then first load one edge later.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds outputs `perf_fetched[31:0]`, incremented on every `ld`.
  - Adds `perf_bubbles[31:0]`, incremented on every RUN cycle in which `if_valid=0` after the edge (redirect or idle slot).
  - Both counters clear on `rst` and wrap at 2^32.
- Not defined: the counter ports and logic are absent, and the block behaves identically otherwise.

## Test plan
- Reset then `id_ready=1` for 5 cycles, memory preloaded with words 0..4 -> `if_pc` sequence 0,1,2,3,4 valid back-to-back, first valid two edges after reset release.
- Stall: `id_ready=0` for 3 cycles while `if_pc=8` -> `if_pc=8` and `if_ir` held, `imem_addr=9` held; on release `if_pc=9` the next cycle.
- Redirect to 78 while stalled at `if_pc=20` -> next edge `if_valid=0` and `imem_addr=78`; following edge `if_pc=78`, `if_valid=1`.
- Redirect and `rst` asserted together -> all reset values; PC=`RESET_PC`, not the redirect target.
- Wrap: redirect to 16383 -> `if_pc` 16383 then 0.
- With `FETCH_PERF_CNT_EN`: 10 sequential fetches plus one redirect -> `perf_fetched=10`, `perf_bubbles=1` (excluding the IDLE cycle).
